// File: rtl/yuv_chroma_subsampler_pkg.sv
// Shared dtype codes and chroma-mode encodings for the YUV subsampler and
// the packers downstream of it.
package yuv_chroma_subsampler_pkg;

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL       = 4'h0;
    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START   = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END     = 4'h4;

    typedef enum logic [1:0] {
        MODE_444  = 2'd0,
        MODE_422  = 2'd1,
        MODE_420  = 2'd2,
        MODE_MONO = 2'd3
    } yuv_mode_e;

    function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
        return dt == DT_PIXEL;
    endfunction

endpackage

// File: rtl/yuv_chroma_subsampler_chroma_avg2.sv
// Combinational average of two chroma samples, round-half-up or truncating.
module chroma_avg2 #(
    parameter int PIXEL_WIDTH = 10,
    parameter int ROUND       = 1
) (
    input  logic [PIXEL_WIDTH-1:0] a,
    input  logic [PIXEL_WIDTH-1:0] b,
    output logic [PIXEL_WIDTH-1:0] avg
);

    // One extra bit holds the full sum, so max+max+1 cannot wrap.
    function automatic logic [PIXEL_WIDTH-1:0] avg_round(
        input logic [PIXEL_WIDTH-1:0] x,
        input logic [PIXEL_WIDTH-1:0] y
    );
        logic [PIXEL_WIDTH:0] sum;
        sum = {1'b0, x} + {1'b0, y} + {{PIXEL_WIDTH{1'b0}}, (ROUND != 0)};
        return sum[PIXEL_WIDTH:1];
    endfunction

    assign avg = avg_round(a, b);

endmodule

// File: rtl/yuv_chroma_subsampler.sv
// 4:4:4 YUV stream to luma plus horizontally averaged, optionally vertically
// decimated chroma (444/422/420/mono); fixed two-clock latency for every beat.
module yuv_chroma_subsampler
    import yuv_chroma_subsampler_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_COLS    = 1920,
    parameter int ROUND       = 1,
    localparam int COL_W      = $clog2(MAX_COLS + 1)
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [1:0]             mode,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]  meta_datai,
    input  logic [PIXEL_WIDTH-1:0] yi,
    input  logic [PIXEL_WIDTH-1:0] ui,
    input  logic [PIXEL_WIDTH-1:0] vi,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]  meta_datao,
    output logic [PIXEL_WIDTH-1:0] yo,
    output logic [PIXEL_WIDTH-1:0] uo,
    output logic [PIXEL_WIDTH-1:0] vo,
    output logic                   uv_valid,
    output logic [COL_W-1:0]       colo,
    output logic                   odd_width_err
);

    localparam logic [COL_W-1:0]       COL_MAX = COL_W'(MAX_COLS);
    localparam logic [PIXEL_WIDTH-1:0] UV_MID  = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};

    yuv_mode_e              mode_shadow_q, mode_shadow_d;
    logic                   row_par_q, row_par_d;
    logic                   col_par_q, col_par_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic                   err_q, err_d;
    logic                   vld_p1_q, vld_p1_d;
    logic                   pix_p1_q, pix_p1_d;

    logic [DTYPE_WIDTH-1:0] dtype_p1_q, dtype_p1_d;
    logic [DATA_WIDTH-1:0]  meta_p1_q, meta_p1_d;
    logic [PIXEL_WIDTH-1:0] y_p1_q, y_p1_d;
    logic [PIXEL_WIDTH-1:0] u_p1_q, u_p1_d;
    logic [PIXEL_WIDTH-1:0] v_p1_q, v_p1_d;
    logic [COL_W-1:0]       col_p1_q, col_p1_d;
    logic                   col_par_p1_q, col_par_p1_d;
    logic                   row_par_p1_q, row_par_p1_d;
    yuv_mode_e              mode_p1_q, mode_p1_d;

    logic                   dvo_q, dvo_d;
    logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
    logic [DATA_WIDTH-1:0]  metao_q, metao_d;
    logic [PIXEL_WIDTH-1:0] yo_q, yo_d;
    logic [PIXEL_WIDTH-1:0] uo_q, uo_d;
    logic [PIXEL_WIDTH-1:0] vo_q, vo_d;
    logic                   uv_valid_q, uv_valid_d;
    logic [COL_W-1:0]       colo_q, colo_d;
    logic                   err_o_q, err_o_d;
    logic [PIXEL_WIDTH-1:0] u_stash_q, u_stash_d;
    logic [PIXEL_WIDTH-1:0] v_stash_q, v_stash_d;

    logic [PIXEL_WIDTH-1:0] u_avg, v_avg;

    chroma_avg2 #(.PIXEL_WIDTH(PIXEL_WIDTH), .ROUND(ROUND)) u_avg2 (
        .a   (u_stash_q),
        .b   (u_p1_q),
        .avg (u_avg)
    );

    chroma_avg2 #(.PIXEL_WIDTH(PIXEL_WIDTH), .ROUND(ROUND)) v_avg2 (
        .a   (v_stash_q),
        .b   (v_p1_q),
        .avg (v_avg)
    );

    // Stage 1: register the beat, tagging pixels with the position/mode they belong to
    always_comb begin
        mode_shadow_d = mode_shadow_q;
        row_par_d     = row_par_q;
        col_par_d     = col_par_q;
        col_d         = col_q;
        err_d         = err_q;
        vld_p1_d      = dvi;
        pix_p1_d      = dvi && is_pixel(dtypei);
        dtype_p1_d    = dtypei;
        meta_p1_d     = meta_datai;
        y_p1_d        = yi;
        u_p1_d        = ui;
        v_p1_d        = vi;
        col_p1_d      = col_q;
        col_par_p1_d  = col_par_q;
        row_par_p1_d  = row_par_q;
        mode_p1_d     = mode_shadow_q;
        if (dvi) begin
            if (dtypei == DT_FRAME_START) begin
                mode_shadow_d = yuv_mode_e'(mode);
                row_par_d     = 1'b0;
                err_d         = 1'b0;
            end else if (dtypei == DT_ROW_START) begin
                col_d     = '0;
                col_par_d = 1'b0;
            end else if (dtypei == DT_ROW_END) begin
                if (col_par_q && (mode_shadow_q == MODE_422 || mode_shadow_q == MODE_420))
                    err_d = 1'b1;
                row_par_d = ~row_par_q;
            end else if (is_pixel(dtypei)) begin
                if (col_q != COL_MAX)
                    col_d = col_q + COL_W'(1);
                col_par_d = ~col_par_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            mode_shadow_q <= MODE_444;
            row_par_q     <= 1'b0;
            col_par_q     <= 1'b0;
            col_q         <= '0;
            err_q         <= 1'b0;
            vld_p1_q      <= 1'b0;
            pix_p1_q      <= 1'b0;
        end else begin
            mode_shadow_q <= mode_shadow_d;
            row_par_q     <= row_par_d;
            col_par_q     <= col_par_d;
            col_q         <= col_d;
            err_q         <= err_d;
            vld_p1_q      <= vld_p1_d;
            pix_p1_q      <= pix_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        dtype_p1_q   <= dtype_p1_d;
        meta_p1_q    <= meta_p1_d;
        y_p1_q       <= y_p1_d;
        u_p1_q       <= u_p1_d;
        v_p1_q       <= v_p1_d;
        col_p1_q     <= col_p1_d;
        col_par_p1_q <= col_par_p1_d;
        row_par_p1_q <= row_par_p1_d;
        mode_p1_q    <= mode_p1_d;
    end

    // Stage 2: produce luma/chroma; even columns stash, odd columns emit the average
    always_comb begin
        dvo_d      = vld_p1_q;
        dtypeo_d   = dtypeo_q;
        metao_d    = metao_q;
        yo_d       = yo_q;
        uo_d       = uo_q;
        vo_d       = vo_q;
        uv_valid_d = 1'b0;
        colo_d     = colo_q;
        err_o_d    = err_q;
        u_stash_d  = u_stash_q;
        v_stash_d  = v_stash_q;
        if (vld_p1_q) begin
            dtypeo_d = dtype_p1_q;
            metao_d  = meta_p1_q;
            if (pix_p1_q) begin
                yo_d   = y_p1_q;
                colo_d = col_p1_q;
                case (mode_p1_q)
                    MODE_444: begin
                        uo_d       = u_p1_q;
                        vo_d       = v_p1_q;
                        uv_valid_d = 1'b1;
                    end
                    MODE_422, MODE_420: begin
                        if (mode_p1_q == MODE_422 || !row_par_p1_q) begin
                            if (!col_par_p1_q) begin
                                u_stash_d = u_p1_q;
                                v_stash_d = v_p1_q;
                            end else begin
                                uo_d       = u_avg;
                                vo_d       = v_avg;
                                uv_valid_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        uo_d = UV_MID;
                        vo_d = UV_MID;
                    end
                endcase
            end else if (dtype_p1_q == DT_ROW_START) begin
                u_stash_d = '0;
                v_stash_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            dvo_q      <= 1'b0;
            dtypeo_q   <= '0;
            metao_q    <= '0;
            yo_q       <= '0;
            uo_q       <= '0;
            vo_q       <= '0;
            uv_valid_q <= 1'b0;
            colo_q     <= '0;
            err_o_q    <= 1'b0;
            u_stash_q  <= '0;
            v_stash_q  <= '0;
        end else begin
            dvo_q      <= dvo_d;
            dtypeo_q   <= dtypeo_d;
            metao_q    <= metao_d;
            yo_q       <= yo_d;
            uo_q       <= uo_d;
            vo_q       <= vo_d;
            uv_valid_q <= uv_valid_d;
            colo_q     <= colo_d;
            err_o_q    <= err_o_d;
            u_stash_q  <= u_stash_d;
            v_stash_q  <= v_stash_d;
        end
    end

    assign dvo           = dvo_q;
    assign dtypeo        = dtypeo_q;
    assign meta_datao    = metao_q;
    assign yo            = yo_q;
    assign uo            = uo_q;
    assign vo            = vo_q;
    assign uv_valid      = uv_valid_q;
    assign colo          = colo_q;
    assign odd_width_err = err_o_q;

endmodule

// File: doc/yuv_chroma_subsampler.md
Name: yuv_chroma_subsampler

Overview:
- Parametrised successor to uv_offset in the imager pipeline.
- Takes a 4:4:4 YUV pixel stream (dvi/dtypei/yi/ui/vi/meta_datai) and produces a luma stream plus horizontally averaged, optionally vertically decimated chroma.
- Modes: 4:4:4, 4:2:2, 4:2:0 and mono.
- Sits between colour conversion and rotate2rams_yuv420 or any packer that consumes chroma strobes.

Parameters:
- PIXEL_WIDTH, 10, bits per Y/U/V sample.
- DATA_WIDTH, 16, meta_data width.
- MAX_COLS, 1920, maximum pixels per row; sizes the column counter to clog2(MAX_COLS+1).
- ROUND, 1, 1 = round-half-up when averaging chroma; 0 = truncate.

Ports:
- clk  in  1  pixel clock.
- resetb  in  1  synchronous, active-low reset.
- mode  in  2  0=444, 1=422, 2=420, 3=mono; shadowed at FRAME_START.
- dvi  in  1  input data valid.
- dtypei  in  `DTYPE_WIDTH  input data type (dtypes.v codes).
- meta_datai  in  DATA_WIDTH  sideband data.
- yi, ui, vi  in  PIXEL_WIDTH each  input samples.
- dvo  out  1  output valid.
- dtypeo  out  `DTYPE_WIDTH  delayed dtype.
- meta_datao  out  DATA_WIDTH  delayed meta data.
- yo  out  PIXEL_WIDTH  luma.
- uo, vo  out  PIXEL_WIDTH  chroma; meaningful only when uv_valid=1.
- uv_valid  out  1  chroma strobe, qualifies uo/vo on a pixel beat.
- colo  out  clog2(MAX_COLS+1)  column index of the pixel on yo.
- odd_width_err  out  1  sticky flag: a row ended on an even column in mode 1/2.

Behaviour:
- Reset (resetb=0 at a clk edge): all outputs 0; col/row parity 0; mode_shadow=0; pending chroma registers 0.
- Fixed latency of 2 clk for every beat. Non-pixel dtypes traverse the same pipe, so ordering is preserved. dvo follows dvi delayed by 2, with no bubbles inserted or removed.
- Stage 1 registers the inputs and decodes dtypes.
  - FRAME_START: mode_shadow<=mode; row_parity<=0; odd_width_err<=0.
  - ROW_START: col<=0; col_parity<=0.
  - ROW_END: if col_parity=1 and mode_shadow is 1 or 2, set odd_width_err. Then toggle row_parity.
  - Pixel beat: col++ (saturating at MAX_COLS); toggle col_parity.
- Stage 2 produces the outputs on a pixel beat.
  - yo = stage1 y; colo = stage1 col.
  - Mode 0: uo/vo = own chroma; uv_valid=1.
  - Mode 1, even column: stash u/v; uv_valid=0; uo/vo hold their last value.
  - Mode 1, odd column: uo = (u_even + u_odd + ROUND) >> 1 in a PIXEL_WIDTH+1 intermediate, result cannot overflow; vo likewise; uv_valid=1.
  - Mode 2: same as mode 1 on rows with row_parity=0. On row_parity=1 rows, uv_valid=0 and uo/vo hold.
  - Mode 3: uv_valid=0; uo=vo=2^(PIXEL_WIDTH-1).
- On non-pixel beats, uv_valid=0, yo/colo hold, and dtypeo/meta_datao pass through.
- Orphan last pixel of an odd-width row in mode 1/2: yo is emitted, uv_valid=0, and its stash is discarded at the next ROW_START.
- A mode change mid-frame has no effect until the next FRAME_START.
- A pixel beat with no preceding ROW_START is still counted, continuing from the current col.
- Reset mid-frame: pipe is flushed and no partial beat is emitted. The stream resumes correctly from the next FRAME_START.
- dvi=0 cycles: the pipe advances with dvo=0. Stash and parity are unaffected.

Decomposition:
- dtypes.v (shared include) holds the dtype codes FRAME_START/ROW_START/ROW_END/FRAME_END and the pixel-type test.
- Mode encodings become named constants in a shared yuv_modes include, reused by packers.
- One natural sub-module: chroma_avg2 (PIXEL_WIDTH, ROUND), a combinational two-sample average with rounding. It is instantiated twice (U and V).

Test Plan:
- Mode 1, PIXEL_WIDTH=10, ROUND=1, row u={100,103,0,1023} -> uv_valid on columns 1 and 3 only; uo=102 then 512; latency exactly 2 clk.
- Mode 2, 4 rows × 4 columns -> uv_valid count 4 (rows 0 and 2 only); yo on all 16 pixels; colo 0..3 each row.
- Mode 3 -> uo=vo=512 and uv_valid never asserted; yo bit-exact to yi.
- mode switched 0->1 between pixels mid-frame -> that frame stays 444 (uv_valid every pixel); 422 behaviour starts after the next FRAME_START.
- Odd-width row of 5 pixels in mode 1 -> 2 uv_valid beats; odd_width_err=1 after ROW_END; flag cleared at the next FRAME_START.
- resetb low for 1 clk mid-row, dvi gapped with random idles -> all outputs 0 the next cycle. The following frame matches the reference model, and dtype ordering is preserved.
